// File: rtl/nios_multi_timer_pkg.sv
// Shared register offsets and bit positions for the multi-channel interval timer.
// Optional compare/PWM feature is enabled by defining MULTI_TIMER_PWM_EN.
package nios_multi_timer_pkg;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t REG_STATUS  = 3'd0;
  localparam reg_idx_t REG_CONTROL = 3'd1;
  localparam reg_idx_t REG_PERIOD  = 3'd2;
  localparam reg_idx_t REG_SNAP    = 3'd3;
  localparam reg_idx_t REG_COMPARE = 3'd4;

  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

endpackage

// File: rtl/nios_multi_timer_ch.sv
// One timer channel: down-counter with PERIOD reload, RUN/TO state, SNAP capture.
// COMPARE register and registered pwm output exist only with MULTI_TIMER_PWM_EN.
module nios_multi_timer_ch
  import nios_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PERIOD_RESET = 49999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_status,
  input  logic        wr_control,
  input  logic        wr_period,
  input  logic        wr_snap,
`ifdef MULTI_TIMER_PWM_EN
  input  logic        wr_compare,
`endif
  input  logic [31:0] writedata,
  input  reg_idx_t    reg_sel,
  output logic [31:0] rd_data,
  output logic        irq_req,
  output logic        pwm
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(PERIOD_RESET);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] snap;
  logic [1:0]       ctrl;
  logic             run;
  logic             to;
  logic             force_reload;
  logic             zero_d;
  logic             cnt_zero;
  logic             timeout_evt;
  logic             start_req;
  logic             stop_req;

  assign cnt_zero    = (counter == '0);
  assign timeout_evt = cnt_zero & ~zero_d;
  assign start_req   = wr_control & writedata[CTRL_START];
  assign stop_req    = wr_control & writedata[CTRL_STOP];
  assign irq_req     = to & ctrl[CTRL_ITO];

  // START has priority over every RUN-clearing source, so a START issued
  // alongside the PERIOD-write reload still leaves the channel running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter      <= RST_VAL;
      period       <= RST_VAL;
      snap         <= '0;
      ctrl         <= '0;
      run          <= 1'b0;
      to           <= 1'b0;
      force_reload <= 1'b0;
      zero_d       <= (RST_VAL == '0);
    end else begin
      force_reload <= wr_period;
      zero_d       <= cnt_zero;
      if (wr_period)
        period <= writedata[CNT_W-1:0];
      if (wr_control)
        ctrl <= {writedata[CTRL_CONT], writedata[CTRL_ITO]};
      if (wr_snap)
        snap <= counter;
      if (run || force_reload)
        counter <= (cnt_zero || force_reload) ? period : counter - CNT_W'(1);
      if (start_req)
        run <= 1'b1;
      else if (stop_req || force_reload || (cnt_zero && !ctrl[CTRL_CONT]))
        run <= 1'b0;
      if (wr_status)
        to <= 1'b0;
      else if (timeout_evt)
        to <= 1'b1;
    end
  end

`ifdef MULTI_TIMER_PWM_EN
  logic [CNT_W-1:0] compare;
  logic             pwm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare <= '0;
      pwm_q   <= 1'b0;
    end else begin
      if (wr_compare)
        compare <= writedata[CNT_W-1:0];
      pwm_q <= run & (counter < compare);
    end
  end

  assign pwm = pwm_q;
`else
  assign pwm = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[STATUS_RUN] = run;
        rd_data[STATUS_TO]  = to;
      end
      REG_CONTROL: begin
        rd_data[CTRL_CONT] = ctrl[CTRL_CONT];
        rd_data[CTRL_ITO]  = ctrl[CTRL_ITO];
      end
      REG_PERIOD:  rd_data[CNT_W-1:0] = period;
      REG_SNAP:    rd_data[CNT_W-1:0] = snap;
`ifdef MULTI_TIMER_PWM_EN
      REG_COMPARE: rd_data[CNT_W-1:0] = compare;
`endif
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: rtl/nios_multi_timer.sv
// Multi-channel Avalon-MM interval timer: write decode, channel array, registered read mux, irq OR.
// Define MULTI_TIMER_PWM_EN to implement per-channel COMPARE registers and pwm_out.
module nios_multi_timer
  import nios_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PERIOD_RESET = 49999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)+2:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      irq,
  output logic [NUM_CH-1:0]         pwm_out
);

  localparam int AW = $clog2(NUM_CH) + 3;

  logic          wr_en;
  logic [AW-1:0] ch_sel;
  reg_idx_t      reg_sel;
  logic [31:0]   ch_rd [NUM_CH];
  logic [NUM_CH-1:0] irq_req;
  logic [31:0]   rd_next;

  assign wr_en   = chipselect & ~write_n;
  assign ch_sel  = address >> 3;
  assign reg_sel = address[2:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = wr_en && (ch_sel == AW'(g));

    nios_multi_timer_ch #(
      .CNT_W        (CNT_W),
      .PERIOD_RESET (PERIOD_RESET)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_status  (sel && (reg_sel == REG_STATUS)),
      .wr_control (sel && (reg_sel == REG_CONTROL)),
      .wr_period  (sel && (reg_sel == REG_PERIOD)),
      .wr_snap    (sel && (reg_sel == REG_SNAP)),
`ifdef MULTI_TIMER_PWM_EN
      .wr_compare (sel && (reg_sel == REG_COMPARE)),
`endif
      .writedata  (writedata),
      .reg_sel    (reg_sel),
      .rd_data    (ch_rd[g]),
      .irq_req    (irq_req[g]),
      .pwm        (pwm_out[g])
    );
  end

  // Addresses whose channel field exceeds NUM_CH-1 fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i))
        rd_next = ch_rd[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

  assign irq = |irq_req;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Directed self-checking bench for nios_multi_timer (4 channels, 32-bit counters).
// PWM expectations follow MULTI_TIMER_PWM_EN as defined for the build.
module tb_nios_multi_timer;
  import nios_multi_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  pwm_out;

  int checks = 0;
  int errors = 0;

  nios_multi_timer #(
    .NUM_CH       (4),
    .CNT_W        (32),
    .PERIOD_RESET (49999)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] reg_addr(input int ch, input logic [2:0] r);
    return {ch[1:0], r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called on a falling edge; the write is sampled on the next rising edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    data       = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int pwm_count;

    $display("[TB] starting");
    idle(3);
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("reset_pwm", {28'd0, pwm_out}, 32'd0);
    reset = 1'b0;

    for (int ch = 0; ch < 4; ch++) begin
      readReg(reg_addr(ch, REG_PERIOD), rd);
      checkOutput($sformatf("reset_period_ch%0d", ch), rd, 32'd49999);
      readReg(reg_addr(ch, REG_STATUS), rd);
      checkOutput($sformatf("reset_status_ch%0d", ch), rd, 32'd0);
    end
    idle(5);
    applyStimulus(reg_addr(0, REG_SNAP), 32'd0);
    readReg(reg_addr(0, REG_SNAP), rd);
    checkOutput("idle_counter_holds", rd, 32'd49999);

    // CH1 continuous with interrupt
    applyStimulus(reg_addr(1, REG_PERIOD), 32'd9);
    applyStimulus(reg_addr(1, REG_CONTROL), 32'h7);
    idle(9);
    checkOutput("ch1_irq_before_timeout", {31'd0, irq}, 32'd0);
    idle(1);
    checkOutput("ch1_irq_at_timeout", {31'd0, irq}, 32'd1);
    readReg(reg_addr(1, REG_STATUS), rd);
    checkOutput("ch1_status_run_to", rd, 32'd3);
    readReg(reg_addr(0, REG_STATUS), rd);
    checkOutput("ch0_status_unaffected", rd, 32'd0);
    readReg(reg_addr(2, REG_STATUS), rd);
    checkOutput("ch2_status_unaffected", rd, 32'd0);
    readReg(reg_addr(3, REG_STATUS), rd);
    checkOutput("ch3_status_unaffected", rd, 32'd0);
    applyStimulus(reg_addr(1, REG_STATUS), 32'd0);
    checkOutput("ch1_irq_cleared", {31'd0, irq}, 32'd0);
    readReg(reg_addr(1, REG_STATUS), rd);
    checkOutput("ch1_status_after_clear", rd, 32'd2);
    readReg(reg_addr(1, REG_CONTROL), rd);
    checkOutput("ch1_control_readback", rd, 32'd3);
    applyStimulus(reg_addr(1, REG_CONTROL), 32'h8);

    // CH0 one-shot
    applyStimulus(reg_addr(0, REG_PERIOD), 32'd4);
    applyStimulus(reg_addr(0, REG_CONTROL), 32'h4);
    idle(5);
    readReg(reg_addr(0, REG_STATUS), rd);
    checkOutput("ch0_oneshot_status", rd, 32'd1);
    checkOutput("ch0_no_irq_without_ito", {31'd0, irq}, 32'd0);
    idle(10);
    applyStimulus(reg_addr(0, REG_SNAP), 32'd0);
    readReg(reg_addr(0, REG_SNAP), rd);
    checkOutput("ch0_reloaded_and_held", rd, 32'd4);
    applyStimulus(reg_addr(0, REG_STATUS), 32'd0);
    idle(20);
    readReg(reg_addr(0, REG_STATUS), rd);
    checkOutput("ch0_single_timeout", rd, 32'd0);

    // CH2 START+STOP together, then clear coinciding with timeout
    applyStimulus(reg_addr(2, REG_PERIOD), 32'd3);
    applyStimulus(reg_addr(2, REG_CONTROL), 32'hC);
    readReg(reg_addr(2, REG_STATUS), rd);
    checkOutput("ch2_start_wins", rd, 32'd2);
    idle(2);
    applyStimulus(reg_addr(2, REG_STATUS), 32'd0);
    readReg(reg_addr(2, REG_STATUS), rd);
    checkOutput("ch2_clear_beats_timeout", rd, 32'd0);

    // CH3 snapshot while counting down from 100
    applyStimulus(reg_addr(3, REG_PERIOD), 32'd100);
    applyStimulus(reg_addr(3, REG_CONTROL), 32'h6);
    idle(20);
    applyStimulus(reg_addr(3, REG_SNAP), 32'd0);
    checkOutput("snap_read_latency", readdata, 32'd0);
    readReg(reg_addr(3, REG_SNAP), rd);
    checkOutput("ch3_snap_value", rd, 32'd80);
    applyStimulus(reg_addr(3, REG_CONTROL), 32'h8);

    // CH2 PERIOD=0 while running continuously
    applyStimulus(reg_addr(2, REG_PERIOD), 32'd0);
    applyStimulus(reg_addr(2, REG_CONTROL), 32'h7);
    idle(3);
    checkOutput("ch2_zero_period_irq", {31'd0, irq}, 32'd1);
    readReg(reg_addr(2, REG_STATUS), rd);
    checkOutput("ch2_zero_period_status", rd, 32'd3);
    applyStimulus(reg_addr(2, REG_STATUS), 32'd0);
    idle(10);
    readReg(reg_addr(2, REG_STATUS), rd);
    checkOutput("ch2_zero_period_one_event", rd, 32'd2);
    applyStimulus(reg_addr(2, REG_CONTROL), 32'h8);
    checkOutput("ch2_irq_after_stop", {31'd0, irq}, 32'd0);

    // CH1 compare / pwm
    applyStimulus(reg_addr(1, REG_PERIOD), 32'd9);
    applyStimulus(reg_addr(1, REG_COMPARE), 32'd3);
    applyStimulus(reg_addr(1, REG_CONTROL), 32'h7);
    idle(5);
    pwm_count = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pwm_out[1]) pwm_count++;
    end
    checkOutput("pwm_other_channels", {28'd0, pwm_out & 4'b1101}, 32'd0);
    readReg(reg_addr(1, REG_COMPARE), rd);
`ifdef MULTI_TIMER_PWM_EN
    checkOutput("pwm_high_count", 32'(pwm_count), 32'd9);
    checkOutput("compare_readback", rd, 32'd3);
`else
    checkOutput("pwm_high_count", 32'(pwm_count), 32'd0);
    checkOutput("compare_readback", rd, 32'd0);
`endif
    readReg(reg_addr(1, 3'd5), rd);
    checkOutput("unused_reg_reads_zero", rd, 32'd0);
    checkOutput("ch1_irq_running", {31'd0, irq}, 32'd1);

    // Asynchronous reset in the middle of a clock phase
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_irq", {31'd0, irq}, 32'd0);
    checkOutput("async_reset_pwm", {28'd0, pwm_out}, 32'd0);
    checkOutput("async_reset_readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    readReg(reg_addr(1, REG_PERIOD), rd);
    checkOutput("post_reset_period", rd, 32'd49999);
    readReg(reg_addr(1, REG_STATUS), rd);
    checkOutput("post_reset_status", rd, 32'd0);
    readReg(reg_addr(1, REG_COMPARE), rd);
    checkOutput("post_reset_compare", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
